// File: rtl/pio_shift_if.sv
// FIFO-side handshake bundle for pio_shift_unit: autopush toward the RX FIFO and
// autopull from the TX FIFO. The master side is the shift unit.
interface pio_shift_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] push_data;
    logic             push_valid;
    logic             push_ready;
    logic [WIDTH-1:0] pull_data;
    logic             pull_valid;
    logic             pull_ready;

    modport master (
        output push_data, push_valid, pull_ready,
        input  push_ready, pull_data, pull_valid
    );

    modport slave (
        input  push_data, push_valid, pull_ready,
        output push_ready, pull_data, pull_valid
    );
endinterface

// File: rtl/pio_shift_unit.sv
// PIO ISR/OSR shift register with saturating shift counter.
// Autopush/autopull handshakes are built only when SHIFTER_AUTO_EN is defined.
module pio_shift_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             penable,
    input  logic [WIDTH-1:0] din,
    input  logic [CNT_W-1:0] shift,
    input  logic             dir,
    input  logic             do_shift,
    input  logic             set,
    input  logic [CNT_W-1:0] thresh,
    input  logic             auto_pull,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] sreg,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             stall,
    pio_shift_if.master      fifo
);
    localparam logic [CNT_W-1:0] W_C = CNT_W'(WIDTH);

    // Shift amount and threshold: 0 encodes WIDTH, larger values clamp to WIDTH.
    function automatic logic [CNT_W-1:0] decode_amt(input logic [CNT_W-1:0] v);
        return (v == '0 || v > W_C) ? W_C : v;
    endfunction

    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [CNT_W-1:0] n_eff;
    logic [CNT_W-1:0] thresh_eff;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] din_m;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] shifted_out;
    logic [CNT_W:0]   count_sum;
    logic [CNT_W-1:0] count_shift;
    logic             set_act;
    logic             shift_req;

    assign n_eff      = decode_amt(shift);
    assign thresh_eff = decode_amt(thresh);
    assign full       = count_q >= thresh_eff;
    assign set_act    = penable & set;
    assign shift_req  = penable & do_shift & ~set_act;

    // A shift by WIDTH falls out naturally: the mask becomes all ones and the
    // opposite-direction shift amount becomes zero.
    assign mask        = ~({WIDTH{1'b1}} << n_eff);
    assign din_m       = din & mask;
    assign shifted     = dir ? ((sreg_q >> n_eff) | (din_m << (W_C - n_eff)))
                             : ((sreg_q << n_eff) | din_m);
    assign shifted_out = dir ? (sreg_q & mask) : (sreg_q >> (W_C - n_eff));
    assign count_sum   = {1'b0, count_q} + {1'b0, n_eff};
    assign count_shift = (count_sum > {1'b0, W_C}) ? W_C : count_sum[CNT_W-1:0];

`ifdef SHIFTER_AUTO_EN
    logic [WIDTH-1:0] push_data_q, push_data_d;
    logic             push_valid_q, push_valid_d;
    logic             pull_go;

    assign fifo.pull_ready = auto_pull & full;
    assign pull_go         = fifo.pull_ready & fifo.pull_valid;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        sreg_d       = sreg_q;
        dout_d       = dout_q;
        count_d      = count_q;
        push_valid_d = push_valid_q;
        push_data_d  = push_data_q;
        stall        = 1'b0;

        if (push_valid_q)
            stall = do_shift & ~set_act;
        else if (auto_pull)
            stall = do_shift & full & ~set_act;

        if (set_act) begin
            sreg_d       = din;
            count_d      = '0;
            push_valid_d = 1'b0;
        end else if (push_valid_q && fifo.push_ready) begin
            sreg_d       = '0;
            count_d      = '0;
            push_valid_d = 1'b0;
        end else if (pull_go) begin
            sreg_d  = fifo.pull_data;
            count_d = '0;
        end else if (shift_req && !stall) begin
            sreg_d  = shifted;
            dout_d  = shifted_out;
            count_d = count_shift;
            if (!auto_pull && count_shift >= thresh_eff) begin
                push_valid_d = 1'b1;
                push_data_d  = shifted;
            end
        end
    end

    assign fifo.push_valid = push_valid_q;
    assign fifo.push_data  = push_data_q;

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            push_valid_q <= 1'b0;
            push_data_q  <= '0;
        end else begin
            push_valid_q <= push_valid_d;
            push_data_q  <= push_data_d;
        end
    end
`else
    logic unused_auto;
    assign unused_auto = ^{auto_pull, fifo.push_ready, fifo.pull_data, fifo.pull_valid};

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        sreg_d  = sreg_q;
        dout_d  = dout_q;
        count_d = count_q;
        if (set_act) begin
            sreg_d  = din;
            count_d = '0;
        end else if (shift_req) begin
            sreg_d  = shifted;
            dout_d  = shifted_out;
            count_d = count_shift;
        end
    end

    assign stall           = 1'b0;
    assign fifo.push_valid = 1'b0;
    assign fifo.push_data  = '0;
    assign fifo.pull_ready = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            sreg_q  <= '0;
            dout_q  <= '0;
            count_q <= '0;
        end else begin
            sreg_q  <= sreg_d;
            dout_q  <= dout_d;
            count_q <= count_d;
        end
    end

    assign sreg  = sreg_q;
    assign dout  = dout_q;
    assign count = count_q;
endmodule

// File: tb/tb_pio_shift_unit.sv
// Directed bench for pio_shift_unit; autopush/autopull steps run only when
// SHIFTER_AUTO_EN is defined, otherwise the disabled-feature outputs are checked.
module tb_pio_shift_unit;
    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             reset;
    logic             penable;
    logic [WIDTH-1:0] din;
    logic [CNT_W-1:0] shift;
    logic             dir;
    logic             do_shift;
    logic             set;
    logic [CNT_W-1:0] thresh;
    logic             auto_pull;
    logic [WIDTH-1:0] dout;
    logic [WIDTH-1:0] sreg;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             stall;

    int total = 0;
    int bad   = 0;

    pio_shift_if #(.WIDTH(WIDTH)) fifo_if ();

    pio_shift_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .penable   (penable),
        .din       (din),
        .shift     (shift),
        .dir       (dir),
        .do_shift  (do_shift),
        .set       (set),
        .thresh    (thresh),
        .auto_pull (auto_pull),
        .dout      (dout),
        .sreg      (sreg),
        .count     (count),
        .full      (full),
        .stall     (stall),
        .fifo      (fifo_if.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

`ifdef SHIFTER_AUTO_EN
    localparam logic AUTO = 1'b1;
`else
    localparam logic AUTO = 1'b0;
`endif

    initial begin
        reset     = 1'b1;
        penable   = 1'b1;
        din       = '0;
        shift     = '0;
        dir       = 1'b1;
        do_shift  = 1'b0;
        set       = 1'b0;
        thresh    = '0;
        auto_pull = 1'b1;
        fifo_if.push_ready = 1'b0;
        fifo_if.pull_data  = '0;
        fifo_if.pull_valid = 1'b0;
        tick();
        tick();

        // Reset arriving while a shift is requested on an all-ones register
        reset = 1'b0;
        set   = 1'b1;
        din   = 32'hFFFF_FFFF;
        tick();
        check("preload_ff", sreg, 32'hFFFF_FFFF);
        set      = 1'b0;
        do_shift = 1'b1;
        shift    = 6'd8;
        reset    = 1'b1;
        tick();
        check("rst_sreg", sreg, 32'h0);
        check("rst_count", 32'(count), 32'h0);
        check("rst_dout", dout, 32'h0);
        check("rst_push_valid", 32'(fifo_if.push_valid), 32'h0);
        check("rst_push_data", fifo_if.push_data, 32'h0);
        reset    = 1'b0;
        do_shift = 1'b0;

        // Parallel load then right shift by 8
        set = 1'b1;
        din = 32'h1234_5678;
        tick();
        check("set_sreg", sreg, 32'h1234_5678);
        check("set_count", 32'(count), 32'h0);
        set      = 1'b0;
        do_shift = 1'b1;
        dir      = 1'b1;
        shift    = 6'd8;
        din      = 32'h0000_00AB;
        tick();
        do_shift = 1'b0;
        check("shr8_sreg", sreg, 32'hAB12_3456);
        check("shr8_dout", dout, 32'h0000_0078);
        check("shr8_count", 32'(count), 32'd8);
        check("shr8_full", 32'(full), 32'h0);

        // Left shift by N=0 (whole word)
        set = 1'b1;
        din = 32'h0000_0001;
        tick();
        check("set_keeps_dout", dout, 32'h0000_0078);
        set      = 1'b0;
        do_shift = 1'b1;
        dir      = 1'b0;
        shift    = 6'd0;
        din      = 32'hCAFE_F00D;
        tick();
        do_shift = 1'b0;
        check("shl32_sreg", sreg, 32'hCAFE_F00D);
        check("shl32_dout", dout, 32'h0000_0001);
        check("shl32_count", 32'(count), 32'd32);
        check("shl32_full", 32'(full), 32'h1);

        // set and do_shift together: set wins, no stall
        set      = 1'b1;
        do_shift = 1'b1;
        din      = 32'h0000_0055;
        #1;
        check("set_shift_stall", 32'(stall), 32'h0);
        tick();
        check("set_shift_sreg", sreg, 32'h0000_0055);
        check("set_shift_count", 32'(count), 32'h0);
        check("set_shift_dout", dout, 32'h0000_0001);
        set      = 1'b0;
        do_shift = 1'b0;

        // penable low gates the shift
        penable  = 1'b0;
        do_shift = 1'b1;
        dir      = 1'b1;
        shift    = 6'd8;
        din      = 32'h0000_00FF;
        tick();
        check("noen_sreg", sreg, 32'h0000_0055);
        check("noen_count", 32'(count), 32'h0);
        penable = 1'b1;

        // Five right shifts by 8: count saturates at 32
        set      = 1'b1;
        do_shift = 1'b0;
        din      = 32'h0;
        tick();
        set      = 1'b0;
        do_shift = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            din = 32'(i);
            tick();
        end
        check("sat4_sreg", sreg, 32'h0403_0201);
        check("sat4_count", 32'(count), 32'd32);
        check("sat4_stall", 32'(stall), 32'(AUTO));
        din = 32'h5;
        tick();
        do_shift = 1'b0;
        check("sat5_count", 32'(count), 32'd32);

        // 20 + 20 saturates at 32
        set = 1'b1;
        din = 32'h0;
        tick();
        set      = 1'b0;
        do_shift = 1'b1;
        shift    = 6'd20;
        tick();
        check("s20_count", 32'(count), 32'd20);
        tick();
        do_shift = 1'b0;
        check("s40_count", 32'(count), 32'd32);

        // Shift amount above WIDTH clamps to a whole-word shift
        set = 1'b1;
        din = 32'hA5A5_A5A5;
        tick();
        set      = 1'b0;
        do_shift = 1'b1;
        dir      = 1'b0;
        shift    = 6'd40;
        din      = 32'h0F0F_0F0F;
        tick();
        do_shift = 1'b0;
        check("clamp_sreg", sreg, 32'h0F0F_0F0F);
        check("clamp_dout", dout, 32'hA5A5_A5A5);
        check("clamp_count", 32'(count), 32'd32);

`ifdef SHIFTER_AUTO_EN
        // Autopush at threshold 16
        auto_pull = 1'b0;
        thresh    = 6'd16;
        set       = 1'b1;
        din       = 32'h0;
        tick();
        set      = 1'b0;
        do_shift = 1'b1;
        dir      = 1'b1;
        shift    = 6'd8;
        din      = 32'h11;
        tick();
        check("push_not_yet", 32'(fifo_if.push_valid), 32'h0);
        din = 32'h22;
        tick();
        check("push_valid", 32'(fifo_if.push_valid), 32'h1);
        check("push_data", fifo_if.push_data, 32'h2211_0000);
        din = 32'h33;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("push_hold_stall", 32'(stall), 32'h1);
            check("push_hold_sreg", sreg, 32'h2211_0000);
            check("push_hold_count", 32'(count), 32'd16);
        end
        do_shift           = 1'b0;
        fifo_if.push_ready = 1'b1;
        tick();
        fifo_if.push_ready = 1'b0;
        check("push_done_sreg", sreg, 32'h0);
        check("push_done_count", 32'(count), 32'h0);
        check("push_done_valid", 32'(fifo_if.push_valid), 32'h0);
`endif

        // Autopull at threshold 32
        auto_pull = 1'b1;
        thresh    = 6'd0;
        set       = 1'b1;
        din       = 32'h0;
        tick();
        set      = 1'b0;
        do_shift = 1'b1;
        dir      = 1'b1;
        shift    = 6'd0;
        din      = 32'h12;
        tick();
        do_shift = 1'b0;
        check("pull_full", 32'(full), 32'h1);
        check("pull_ready", 32'(fifo_if.pull_ready), 32'(AUTO));
        fifo_if.pull_valid = 1'b1;
        fifo_if.pull_data  = 32'hDEAD_BEEF;
        tick();
        fifo_if.pull_valid = 1'b0;
        check("pull_sreg", sreg, AUTO ? 32'hDEAD_BEEF : 32'h0000_0012);
        check("pull_count", 32'(count), AUTO ? 32'h0 : 32'd32);
        check("pull_ready_after", 32'(fifo_if.pull_ready), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
